// File: rtl/mealy_ones_detector_param_if.sv
// Serial-data bus for mealy_ones_detector_param.
// master: the stimulus side (drives ain/en/clr, observes results).
// slave:  the detector itself.
interface mealy_ones_detector_param_if #(
    parameter int CNT_W = 4
);
    logic             ain;
    logic             en;
    logic             clr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] hit_cnt;
    logic             yout;

    modport master (
        output ain,
        output en,
        output clr,
        input  count,
        input  hit_cnt,
        input  yout
    );

    modport slave (
        input  ain,
        input  en,
        input  clr,
        output count,
        output hit_cnt,
        output yout
    );
endinterface

// File: rtl/mealy_ones_detector_param.sv
// Parametrised Mealy ones-count detector.
// yout pulses combinationally on the FIRST-th accepted 1, then on every
// PERIOD-th accepted 1 after that; it also flags 0s seen before any 1.
// Keeps a running count of accepted 1s and a count of 1-hits.
// Build option: define SEQDET_SAT_EN to make both counters saturate at
// all-ones instead of wrapping.
module mealy_ones_detector_param #(
    parameter int CNT_W  = 4,
    parameter int FIRST  = 4,
    parameter int PERIOD = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    mealy_ones_detector_param_if.slave   bus
);

    localparam int MAX_FP = (FIRST > PERIOD) ? FIRST : PERIOD;
    localparam int PH_W   = $clog2(MAX_FP + 1);

    localparam logic [PH_W-1:0] FIRST_M1  = PH_W'(FIRST - 1);
    localparam logic [PH_W-1:0] PERIOD_M1 = PH_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,   // no 1 seen yet
        PRE  = 2'b01,   // 1..FIRST-1 ones seen
        LOOP = 2'b10    // first hit reached, counting periods
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PH_W-1:0]  r_ph;
    logic [PH_W-1:0]  w_ph_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] w_hit_cnt_nxt;
    logic             w_accept;
    logic             w_yout;
    logic             w_hit;

    // A sample only counts when enabled and neither reset nor clear is active.
    assign w_accept = bus.en & ~reset & ~bus.clr;

    // Next state, phase and Mealy output from the current state and input.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_yout      = 1'b0;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (!bus.ain) begin
                        w_yout = 1'b1;          // zero before any 1
                    end else if (FIRST == 1) begin
                        w_state_nxt = LOOP;
                        w_ph_nxt    = '0;
                        w_yout      = 1'b1;
                    end else begin
                        w_state_nxt = PRE;
                        w_ph_nxt    = PH_W'(1);
                    end
                end
                PRE: begin
                    if (bus.ain) begin
                        if (r_ph == FIRST_M1) begin
                            w_state_nxt = LOOP;
                            w_ph_nxt    = '0;
                            w_yout      = 1'b1;
                        end else begin
                            w_ph_nxt = r_ph + PH_W'(1);
                        end
                    end
                end
                LOOP: begin
                    if (bus.ain) begin
                        if (r_ph == PERIOD_M1) begin
                            w_ph_nxt = '0;
                            w_yout   = 1'b1;
                        end else begin
                            w_ph_nxt = r_ph + PH_W'(1);
                        end
                    end
                end
                default: begin
                    // Illegal encoding: recover to a clean start.
                    w_state_nxt = IDLE;
                    w_ph_nxt    = '0;
                end
            endcase
        end
    end

    // A hit is a detection on a 1; IDLE zero-flags carry ain=0 and are excluded.
    assign w_hit = w_yout & bus.ain;

    // Counter next values: wrap by default, saturate when SEQDET_SAT_EN is set.
    always_comb begin
        w_count_nxt   = r_count;
        w_hit_cnt_nxt = r_hit_cnt;
`ifdef SEQDET_SAT_EN
        if (w_accept && bus.ain && (r_count != '1)) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
        if (w_hit && (r_hit_cnt != '1)) begin
            w_hit_cnt_nxt = r_hit_cnt + CNT_W'(1);
        end
`else
        if (w_accept && bus.ain) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
        if (w_hit) begin
            w_hit_cnt_nxt = r_hit_cnt + CNT_W'(1);
        end
`endif
    end

    // State, phase and counters; reset and clear both return to a clean start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset || bus.clr) begin
            r_state   <= IDLE;
            r_ph      <= '0;
            r_count   <= '0;
            r_hit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ph      <= w_ph_nxt;
            r_count   <= w_count_nxt;
            r_hit_cnt <= w_hit_cnt_nxt;
        end
    end

    assign bus.yout    = w_yout;
    assign bus.count   = r_count;
    assign bus.hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_mealy_ones_detector_param.sv
// Directed bench for mealy_ones_detector_param: a vector table on the
// default-parameter instance plus hand sequences for counter wrap/saturation
// on both the default and the FIRST=1/PERIOD=1 instances.
module tb_mealy_ones_detector_param;

    logic clk;
    logic rst_a;
    logic rst_b;

    int checks;
    int failures;

    mealy_ones_detector_param_if #(.CNT_W(4)) bus_a ();
    mealy_ones_detector_param_if #(.CNT_W(4)) bus_b ();

    mealy_ones_detector_param #(.CNT_W(4), .FIRST(4), .PERIOD(3)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    mealy_ones_detector_param #(.CNT_W(4), .FIRST(1), .PERIOD(1)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       reset;
        bit       clr;
        bit       en;
        bit       ain;
        bit       exp_y;      // yout during the cycle
        bit [3:0] exp_count;  // count after the edge
        bit [3:0] exp_hit;    // hit_cnt after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic add(input bit r, input bit c, input bit e, input bit a,
                       input bit y, input int cnt, input int hit);
        vec_t v;
        v.reset = r; v.clr = c; v.en = e; v.ain = a; v.exp_y = y;
        v.exp_count = 4'(cnt); v.exp_hit = 4'(hit);
        vecs.push_back(v);
    endtask

    // One cycle on instance A: drive at negedge, check yout mid-low-phase,
    // check registered outputs just after the rising edge.
    task automatic step_a(input bit r, input bit c, input bit e, input bit a,
                          input bit y, input int cnt, input int hit,
                          input string tag);
        @(negedge clk);
        rst_a = r; bus_a.clr = c; bus_a.en = e; bus_a.ain = a;
        #2;
        check({tag, ".yout"}, 32'(bus_a.yout), 32'(y));
        @(posedge clk);
        #1;
        check({tag, ".count"}, 32'(bus_a.count), 32'(cnt));
        check({tag, ".hit_cnt"}, 32'(bus_a.hit_cnt), 32'(hit));
    endtask

    task automatic step_b(input bit r, input bit a, input bit y, input int cnt,
                          input int hit, input string tag);
        @(negedge clk);
        rst_b = r; bus_b.clr = 1'b0; bus_b.en = 1'b1; bus_b.ain = a;
        #2;
        check({tag, ".yout"}, 32'(bus_b.yout), 32'(y));
        @(posedge clk);
        #1;
        check({tag, ".count"}, 32'(bus_b.count), 32'(cnt));
        check({tag, ".hit_cnt"}, 32'(bus_b.hit_cnt), 32'(hit));
    endtask

    function automatic int model_cnt(input int n);
`ifdef SEQDET_SAT_EN
        return (n > 15) ? 15 : n;
`else
        return n % 16;
`endif
    endfunction

    initial begin
        int ones;
        int hits;
        checks = 0;
        failures = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.ain = 1'b0; bus_a.en = 1'b0; bus_a.clr = 1'b0;
        bus_b.ain = 1'b0; bus_b.en = 1'b0; bus_b.clr = 1'b0;

        // ---- vector table, instance A (FIRST=4, PERIOD=3) ----
        //   rst clr en ain  y  cnt hit
        // reset, two leading zeros, ten ones: hits on 4th, 7th, 10th
        add(1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        for (int i = 1; i <= 10; i++)
            add(0, 0, 1, 1, (i == 4 || i == 7 || i == 10), i,
                (i >= 10) ? 3 : (i >= 7) ? 2 : (i >= 4) ? 1 : 0);
        // pattern 1,1,0,0,1,1,1,1: only the 4th one hits (next hit is the 7th)
        add(1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 0, 2, 0);
        add(0, 0, 1, 0, 0, 2, 0);
        add(0, 0, 1, 0, 0, 2, 0);
        add(0, 0, 1, 1, 0, 3, 0);
        add(0, 0, 1, 1, 1, 4, 1);
        add(0, 0, 1, 1, 0, 5, 1);
        add(0, 0, 1, 1, 0, 6, 1);
        // 3 ones, en=0 for 5 cycles with ain toggling, then a hit on resume
        add(1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 0, 2, 0);
        add(0, 0, 1, 1, 0, 3, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, i[0], 0, 3, 0);
        add(0, 0, 1, 1, 1, 4, 1);
        // 3 ones, clr with ain=1, then 4 ones: hit on the 4th post-clear one
        add(1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 0, 2, 0);
        add(0, 0, 1, 1, 0, 3, 0);
        add(0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 0, 2, 0);
        add(0, 0, 1, 1, 0, 3, 0);
        add(0, 0, 1, 1, 1, 4, 1);
        // reset on a would-be hit, then zero-flag and idle corner cases
        add(1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 0, 2, 0);
        add(0, 0, 1, 1, 0, 3, 0);
        add(1, 0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);   // back in IDLE: zero flag, not counted
        add(0, 0, 0, 0, 0, 0, 0);   // en=0 masks the zero flag
        add(0, 1, 1, 0, 0, 0, 0);   // clr masks the zero flag
        add(0, 0, 1, 1, 0, 1, 0);   // first one after clear is ordinal 1

        foreach (vecs[i])
            step_a(vecs[i].reset, vecs[i].clr, vecs[i].en, vecs[i].ain,
                   vecs[i].exp_y, vecs[i].exp_count, vecs[i].exp_hit,
                   $sformatf("vec%0d", i));

        // ---- hand sequence: 17 ones on A crosses the counter limit ----
        step_a(1, 0, 1, 0, 0, 0, 0, "a_wrap_rst");
        hits = 0;
        for (int n = 1; n <= 17; n++) begin
            bit is_hit;
            is_hit = (n >= 4) && ((n - 4) % 3 == 0);
            if (is_hit) hits++;
            step_a(0, 0, 1, 1, is_hit, model_cnt(n), model_cnt(hits),
                   $sformatf("a_wrap%0d", n));
        end

        // ---- hand sequence: FIRST=1, PERIOD=1, every one is a hit ----
        rst_a = 1'b1;
        step_b(1, 0, 0, 0, 0, "b_rst");
        step_b(0, 0, 1, 0, 0, "b_zero");
        for (int n = 1; n <= 20; n++)
            step_b(0, 1, 1, model_cnt(n), model_cnt(n),
                   $sformatf("b_one%0d", n));
        ones = 20;
        check("b_final.count", 32'(bus_b.count), 32'(model_cnt(ones)));
        check("b_final.hit_cnt", 32'(bus_b.hit_cnt), 32'(model_cnt(ones)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
